// File: rtl/mc_pc_unit.sv
// mc_pc_unit: multicycle CPU program counter, next-PC select and branch-target latch.
module mc_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_pc_write,
    input  logic        i_pc_write_cond,
    input  logic        i_zero,
    input  logic        i_branch_ne,
    input  logic [1:0]  i_pc_src,
    input  logic        i_target_load,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_jump_idx,
    input  logic [31:0] i_reg_target,
    output logic [31:0] o_branch_target,
    output logic [31:0] o_old_pc,
    output logic        o_taken,
    output logic        o_misalign
);
    if (RESET_VECTOR[1:0] != 2'b00) begin : g_align_chk
        $error("mc_pc_unit: RESET_VECTOR must be word aligned");
    end
    logic [31:0] r_pc, r_bt, r_old;
    logic        r_taken, r_mis;
    logic [31:0] w_cand;
    logic        w_we, w_ok;
    always_comb begin
        w_cand = i_pc_src == 2'b00 ? i_pc_plus4 :
                 i_pc_src == 2'b01 ? r_bt :
                 i_pc_src == 2'b10 ? {r_pc[31:28], i_jump_idx, 2'b00} : i_reg_target;
        w_we   = i_pc_write | (i_pc_write_cond & (i_zero ^ i_branch_ne));
        w_ok   = w_we & (w_cand[1:0] == 2'b00);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_bt    <= '0;
            r_old   <= '0;
            r_taken <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_taken <= w_ok & ~i_pc_write;
            if (w_we & ~w_ok)
                r_mis <= 1'b1;
            if (w_ok)
                r_pc <= w_cand;
            if (w_ok & i_pc_write & (i_pc_src == 2'b00))
                r_old <= r_pc;
            // target is computed from the pre-edge PC, even when the PC is written this cycle
            if (i_target_load)
                r_bt <= r_pc + {{14{i_imm[15]}}, i_imm, 2'b00};
        end
    end
    assign o_pc            = r_pc;
    assign o_branch_target = r_bt;
    assign o_old_pc        = r_old;
    assign o_taken         = r_taken;
    assign o_misalign      = r_mis;
endmodule

// File: doc/mc_pc_unit.md
Name: mc_pc_unit

Overview:
- Program-counter register and next-PC selection for the multicycle CPU.
- Drives o_pc into the PC+4 adder and takes the adder result back on i_pc_plus4.
- Also takes the branch offset, jump index and register target from decode/regfile.
- Loads the new PC only when the multicycle controller asserts its PC-write strobes. Holds the branch target and the PC of the current instruction between cycles.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset; bits [1:0] must be 0 (elaboration-time check).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- o_pc  out  32  current PC; feeds instruction memory and the PC+4 adder.
- i_pc_plus4  in  32  o_pc + 4 returned from the adder.
- i_pc_write  in  1  unconditional PC write (fetch, jump cycles).
- i_pc_write_cond  in  1  conditional PC write (branch execute cycle).
- i_zero  in  1  ALU zero flag.
- i_branch_ne  in  1  1 = bne polarity, 0 = beq.
- i_pc_src  in  2  next-PC select: 00 pc+4, 01 branch target, 10 jump, 11 register.
- i_target_load  in  1  latch branch target (decode cycle).
- i_imm  in  16  branch offset, in words.
- i_jump_idx  in  26  jump instruction index.
- i_reg_target  in  32  jr source register value.
- o_branch_target  out  32  latched branch target.
- o_old_pc  out  32  PC of the instruction currently executing.
- o_taken  out  1  one-cycle pulse: conditional write taken.
- o_misalign  out  1  sticky: a write was attempted with a misaligned target.

Behaviour:
- All state updates on rising i_clk.
- Reset when i_rst_n=0 at the edge:
  - o_pc=RESET_VECTOR.
  - o_branch_target=0, o_old_pc=0, o_taken=0, o_misalign=0.
  - Reset overrides every other input, including a write in progress.
- Next-PC candidate, by i_pc_src:
  - 00: i_pc_plus4.
  - 01: o_branch_target.
  - 10: {o_pc[31:28], i_jump_idx, 2'b00}.
  - 11: i_reg_target.
- Condition: cond = i_zero XOR i_branch_ne.
- Write enable: we = i_pc_write | (i_pc_write_cond & cond).
  - If i_pc_write=1, the write is unconditional regardless of cond.
- Alignment rule:
  - If we=1 and candidate[1:0]!=0, o_pc holds and o_misalign sets.
  - o_misalign stays set until reset.
  - Otherwise, if we=1, o_pc takes the candidate next cycle (latency 1).
- o_old_pc loads the pre-update o_pc when i_pc_write=1, i_pc_src=00 and the write is accepted (fetch cycle). It holds otherwise.
- Branch target:
  - On i_target_load=1, o_branch_target <= o_pc + (sign_extend(i_imm) << 2).
  - Uses the pre-edge o_pc, which after fetch already holds PC+4.
  - Arithmetic is 32-bit modulo 2^32; wrap-around is silent and produces no flag.
- o_taken:
  - Is 1 for exactly the cycle after an accepted write with i_pc_write_cond=1, i_pc_write=0 and cond=1.
  - Otherwise it is 0.
  - It is not set by a misaligned (rejected) write.
- Simultaneous events:
  - i_target_load together with a PC write: both happen, and the target uses the old o_pc.
  - i_pc_write_cond=1 with cond=0 and i_pc_write=0: no write, o_taken=0.
- No write strobe asserted: all registers hold, except that o_taken returns to 0.
- i_pc_plus4 is consumed combinationally and is not registered internally.

Test Plan:
- Reset then fetch:
  - Stimulus: hold i_rst_n=0 for 2 cycles, then three fetch cycles with i_pc_write=1, src=00, i_pc_plus4 = o_pc+4.
  - Required: o_pc = 0x0, 0x4, 0x8, 0xC; o_old_pc = 0x0, 0x4, 0x8.
- beq taken and not taken:
  - Setup: o_pc=0x104, i_target_load=1, i_imm=16'hFFFE, giving o_branch_target=0x0FC.
  - Stimulus: write_cond=1, src=01, zero=1.
  - Required: o_pc=0x0FC and one o_taken pulse.
  - Repeat with zero=0: o_pc unchanged, o_taken=0.
- bne polarity:
  - Stimulus: branch_ne=1, zero=0, write_cond=1, src=01, target 0x200.
  - Required: o_pc=0x200, o_taken=1.
- Jump and jr:
  - Jump: o_pc=0x4000_0010, idx=26'h0000100, src=10, pc_write=1 → o_pc=0x4000_0400.
  - jr: i_reg_target=0x0000_0080, src=11 → o_pc=0x80.
- Misalign and wrap-around:
  - Misalign: jr with i_reg_target=0x0000_0082 → o_pc holds, o_misalign=1 and stays 1 through later valid writes until reset.
  - Wrap: o_pc=0xFFFF_FFFC, imm=16'h0001 → o_branch_target=0x0000_0000.
- Reset mid-operation:
  - Stimulus: i_rst_n=0 in the same cycle as pc_write=1, src=10.
  - Required: o_pc=RESET_VECTOR and all other outputs 0.
